// File: rtl/sram_readback_check.sv
// Reads back the SSRAM range written by the pattern generator and checks each word.
// Reports a saturating mismatch count plus the first failing address/data.
module sram_readback_check #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 1024,
  parameter int READ_LAT  = 2,
  parameter int ERR_W     = 16
) (
  input  logic              CLOCK,
  input  logic              nRST,
  input  logic              start,
  input  logic [DATA_W-1:0] bitMask,
  output logic              ren,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0] rData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   fa_q, fa_d;
  logic [DATA_W-1:0]   fd_q, fd_d;
  logic [READ_LAT-1:0] vld_q;
  logic [ADDR_W-1:0]   pa_q [READ_LAT];
  logic                hit;
  logic                drain_last;

  function automatic logic [DATA_W-1:0] exp_word(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] m
  );
    logic [19:0] a20;
    a20 = 20'(a);
    return DATA_W'({a20[11:0], a20}) & m;
  endfunction

  assign ren            = (state_q == ISSUE);
  assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_q == '0);
  assign rAddr          = addr_q;
  assign err_count      = err_q;
  assign first_err_addr = fa_q;
  assign first_err_data = fd_q;

  assign hit = vld_q[READ_LAT-1] &&
               (rData != exp_word(pa_q[READ_LAT-1], mask_q));

  // True when only the output stage may still hold a read in flight
  always_comb begin
    drain_last = 1'b1;
    for (int i = 0; i < READ_LAT - 1; i++) begin
      if (vld_q[i]) drain_last = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    if (hit) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) begin
        fa_d = pa_q[READ_LAT-1];
        fd_d = rData;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          mask_d  = bitMask;
          addr_d  = '0;
          err_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
      ISSUE: begin
        if (addr_q == LAST) state_d = DRAIN;
        else addr_d = addr_q + ADDR_W'(1);
      end
      DRAIN: begin
        if (drain_last) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) pa_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fd_q     <= fd_d;
      vld_q[0] <= ren;
      pa_q[0]  <= addr_q;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        pa_q[i]  <= pa_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_readback_check.sv
// Random-stimulus scoreboard bench for sram_readback_check.
// Two instances: READ_LAT=2/ERR_W=16 and READ_LAT=5/ERR_W=4.
module tb_sram_readback_check;

  localparam int NW = 1024;

  typedef struct {
    int          id;
    int          errs;
    logic [19:0] fa;
    logic [31:0] fd;
    bit          pass;
  } res_t;

  logic        clk = 1'b0;
  logic        nrst  [2];
  logic        start [2];
  logic [31:0] cmask [2];
  logic [31:0] wmask [2];
  int          mode  [2];
  int          salt  [2];
  logic [31:0] flip  [2];

  logic        ren_a   [2];
  logic [19:0] raddr_a [2];
  logic        busy_a  [2];
  logic        done_a  [2];
  logic        pass_a  [2];
  logic [15:0] ec_a    [2];
  logic [19:0] fa_a    [2];
  logic [31:0] fd_a    [2];

  res_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Writer pattern: high 12 bits repeat the low address bits
  function automatic logic [31:0] expw(int a, logic [31:0] m);
    longint v;
    v = ((longint'(a) % 4096) * 1048576) + longint'(a);
    return 32'(v) & m;
  endfunction

  function automatic logic [31:0] memval(int g, int a);
    logic [31:0] e;
    e = expw(a, wmask[g]);
    case (mode[g])
      0: return e;
      1: return (a == 5) ? 32'h0 : ((a == NW - 1) ? (e ^ 32'h1) : e);
      2: return 32'h0;
      default: return (((a * 7 + salt[g]) % 61) == 0) ? (e ^ flip[g]) : e;
    endcase
  endfunction

  function automatic res_t refrun(int g, int ew);
    res_t        r;
    logic [31:0] d;
    r.id   = g;
    r.errs = 0;
    r.fa   = '0;
    r.fd   = '0;
    for (int a = 0; a < NW; a++) begin
      d = memval(g, a);
      if (d != expw(a, cmask[g])) begin
        if (r.errs == 0) begin
          r.fa = 20'(a);
          r.fd = d;
        end
        if (r.errs < (1 << ew) - 1) r.errs++;
      end
    end
    r.pass = (r.errs == 0);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L  = (g == 0) ? 2 : 5;
    localparam int EW = (g == 0) ? 16 : 4;

    logic          ren, busy, done, pass;
    logic [19:0]   raddr, fa;
    logic [31:0]   fd, rdata;
    logic [EW-1:0] ec;
    logic [31:0]   dl [L];

    sram_readback_check #(
      .ADDR_W(20), .DATA_W(32), .NUM_WORDS(NW),
      .READ_LAT(L), .ERR_W(EW)
    ) u_dut (
      .CLOCK(clk), .nRST(nrst[g]), .start(start[g]),
      .bitMask(cmask[g]), .ren(ren), .rAddr(raddr),
      .rData(rdata), .busy(busy), .done(done), .pass(pass),
      .err_count(ec), .first_err_addr(fa), .first_err_data(fd)
    );

    // SSRAM wrapper: data appears L cycles after ren/rAddr are sampled
    always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= ren ? memval(g, int'(raddr)) : 32'hDEAD_BEEF;
    end
    assign rdata = dl[L-1];

    assign ren_a[g]   = ren;
    assign raddr_a[g] = raddr;
    assign busy_a[g]  = busy;
    assign done_a[g]  = done;
    assign pass_a[g]  = pass;
    assign ec_a[g]    = 16'(ec);
    assign fa_a[g]    = fa;
    assign fd_a[g]    = fd;

    initial begin
      int   cyc, nreads, last_ren, idle_cyc;
      bit   seq_ok, prev_done;
      res_t r;
      cyc = 0; nreads = 0; last_ren = 0; idle_cyc = -10;
      seq_ok = 1; prev_done = 0;
      forever begin
        @(negedge clk);
        if (!nrst[g]) begin
          cyc = 0; nreads = 0; idle_cyc = -10;
          seq_ok = 1; prev_done = 0;
        end else begin
          cyc++;
          if (start[g] && !busy && !done && !ren) idle_cyc = cyc;
          if (ren) begin
            if (raddr != 20'(nreads) || !busy) seq_ok = 0;
            if (nreads == 0 && cyc != idle_cyc + 1) seq_ok = 0;
            nreads++;
            last_ren = cyc;
          end
          if (done && !prev_done) begin
            chk($sformatf("u%0d sb_entry", g),
                longint'(sbq.size() > 0 && sbq[0].id == g), 1);
            if (sbq.size() > 0) begin
              r = sbq.pop_front();
              chk($sformatf("u%0d err_count", g), ec, r.errs);
              chk($sformatf("u%0d first_addr", g), fa, r.fa);
              chk($sformatf("u%0d first_data", g), fd, r.fd);
              chk($sformatf("u%0d pass", g), pass, r.pass);
              chk($sformatf("u%0d read_count", g), nreads, NW);
              chk($sformatf("u%0d read_seq", g), seq_ok, 1);
              chk($sformatf("u%0d done_lat", g), cyc - last_ren, L + 1);
            end
            nreads = 0;
            seq_ok = 1;
          end
          prev_done = done;
        end
      end
    end
  end

  task automatic begin_run(int g, int md, logic [31:0] wm,
                           logic [31:0] cm, output res_t r);
    mode[g]  = md;
    wmask[g] = wm;
    cmask[g] = cm;
    salt[g]  = int'($urandom_range(0, 60));
    flip[g]  = $urandom | 32'h1;
    r = refrun(g, (g == 0) ? 16 : 4);
    sbq.push_back(r);
    start[g] = 1'b1;
  endtask

  task automatic end_run(int g, res_t r, bit hold);
    int n;
    n = 0;
    while (!done_a[g] && n < NW + 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d done_reached", g), done_a[g], 1);
    if (hold) begin
      repeat (4) begin
        @(posedge clk); #1;
        chk($sformatf("u%0d done_held", g), done_a[g], 1);
      end
    end
    start[g] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("u%0d idle_after", g), done_a[g] | busy_a[g], 0);
    chk($sformatf("u%0d result_hold", g), ec_a[g], r.errs);
  endtask

  task automatic run(int g, int md, logic [31:0] wm,
                     logic [31:0] cm, bit hold);
    res_t r;
    begin_run(g, md, wm, cm, r);
    end_run(g, r, hold);
  endtask

  task automatic abort_run();
    res_t r;
    res_t dropped;
    int   n;
    begin_run(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
    n = 0;
    while (!(ren_a[0] && raddr_a[0] == 20'h80) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u0 reach_080", raddr_a[0], 'h80);
    chk("u0 pre_abort_errs", ec_a[0], 1);
    nrst[0] = 1'b0;
    #1;
    chk("u0 abort_ren", ren_a[0], 0);
    chk("u0 abort_busy", busy_a[0], 0);
    chk("u0 abort_errs", ec_a[0], 0);
    chk("u0 abort_addr", raddr_a[0], 0);
    dropped = sbq.pop_back();
    @(posedge clk); #1;
    sbq.push_back(r);
    nrst[0] = 1'b1;
    end_run(0, r, 0);
  endtask

  initial begin
    logic [31:0] m;
    for (int g = 0; g < 2; g++) begin
      nrst[g] = 1'b0; start[g] = 1'b0; mode[g] = 0;
      cmask[g] = '0; wmask[g] = '0; salt[g] = 0; flip[g] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst ren", ren_a[0], 0);
    chk("rst raddr", raddr_a[0], 0);
    chk("rst busy", busy_a[0], 0);
    chk("rst done", done_a[0], 0);
    chk("rst pass", pass_a[0], 0);
    chk("rst err", ec_a[0], 0);
    chk("rst faddr", fa_a[0], 0);
    chk("rst fdata", fd_a[0], 0);
    chk("rst u1 done", done_a[1], 0);
    nrst[0] = 1'b1;
    nrst[1] = 1'b1;
    @(posedge clk); #1;

    run(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(0, 0, 32'h0000_FFFF, 32'h0000_FFFF, 0);
    run(0, 0, 32'h0000_FFFF, 32'hFFFF_FFFF, 0);
    repeat (3) begin
      m = $urandom;
      run(0, ($urandom_range(0, 1) == 1) ? 3 : 0, m, m, 0);
    end
    run(0, 0, $urandom, $urandom, 0);
    abort_run();

    run(1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    m = $urandom;
    run(1, 0, m, m, 1);
    m = $urandom;
    run(1, 3, m, m, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
